// File: rtl/fir_pkg.sv
// Shared FIR definitions: data width, capture FSM encoding and saturation bounds.
package fir_pkg;

   localparam int FIR_DATA_WIDTH = 24;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACK  = 2'b01,
      HOLD = 2'b10
   } cap_state_t;

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and an occupancy output.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         iv_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         ov_dout,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   ov_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;
      do_pop   = i_pop && (level_q != '0);
      do_push  = i_push && ((level_q != FULL_LVL) || do_pop);

      if (do_push) begin
         mem_d[wr_ptr_q] = iv_din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // The new head is either the word being written right now or one already in memory.
      if (level_d != '0) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = iv_din;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

   assign ov_dout  = head_q;
   assign o_valid  = (level_q != '0);
   assign ov_level = level_q;

endmodule

// File: rtl/fir_output_requant_fifo.sv
// FIR output stage: captures filter results over a ready-pulse handshake, rounds and
// saturates them to OUT_WIDTH, and queues them for a valid/ready sink.
module fir_output_requant_fifo
   import fir_pkg::*;
#(
   parameter int IN_WIDTH   = FIR_DATA_WIDTH,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_en,
   input  logic [IN_WIDTH-1:0]           iv_din,
   input  logic                          i_din_valid,
   output logic                          o_ready,
   output logic [OUT_WIDTH-1:0]          ov_dout,
   output logic                          o_dout_valid,
   input  logic                          i_dout_ready,
   output logic                          o_sat,
   input  logic                          i_sat_clr,
   output logic [$clog2(FIFO_DEPTH):0]   ov_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = IN_WIDTH + 1;
   localparam logic signed [TW-1:0] RND =
      (SHIFT > 0) ? TW'(64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [63:0] MAXV = sat_max(OUT_WIDTH);
   localparam logic signed [63:0] MINV = sat_min(OUT_WIDTH);

   cap_state_t               state_q, state_d;
   logic [IN_WIDTH-1:0]      din_q, din_d;
   logic                     ready_q, ready_d;
   logic signed [TW-1:0]     s1_q, s1_d;
   logic                     s1_vld_q, s1_vld_d;
   logic [1:0]               inflight_q, inflight_d;
   logic                     sat_q, sat_d;

   logic                     capture, accept, push, pop, clamp;
   logic [LW:0]              occ;
   logic signed [TW-1:0]     ext, sum;
   logic signed [63:0]       s1_wide, clamped;
   logic [OUT_WIDTH-1:0]     push_data;
   logic [LW-1:0]            fifo_level;
   logic                     fifo_valid;

   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      capture    = 1'b0;
      ext        = '0;
      sum        = '0;
      clamped    = '0;
      clamp      = 1'b0;
      inflight_d = inflight_q;
      sat_d      = sat_q;

      // Pipeline contents count against free space; a pop in the same cycle is not credited.
      occ    = (LW+1)'(fifo_level) + (LW+1)'(inflight_q);
      accept = (occ < (LW+1)'(FIFO_DEPTH));

      case (state_q)
         IDLE: begin
            if (i_din_valid && i_en && accept) begin
               din_d   = iv_din;
               capture = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = HOLD;
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = capture;

      ext      = {din_q[IN_WIDTH-1], din_q};
      sum      = ext + RND;
      s1_d     = sum >>> SHIFT;
      s1_vld_d = ready_q;

      push    = s1_vld_q;
      s1_wide = 64'(s1_q);
      if (s1_wide > MAXV) begin
         clamped = MAXV;
         clamp   = 1'b1;
      end else if (s1_wide < MINV) begin
         clamped = MINV;
         clamp   = 1'b1;
      end else begin
         clamped = s1_wide;
      end
      push_data = OUT_WIDTH'(clamped);

      case ({capture, push})
         2'b10:   inflight_d = inflight_q + 2'd1;
         2'b01:   inflight_d = inflight_q - 2'd1;
         default: inflight_d = inflight_q;
      endcase

      if (i_sat_clr) begin
         sat_d = 1'b0;
      end
      if (push && clamp) begin
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         din_q      <= '0;
         ready_q    <= 1'b0;
         s1_q       <= '0;
         s1_vld_q   <= 1'b0;
         inflight_q <= '0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         din_q      <= din_d;
         ready_q    <= ready_d;
         s1_q       <= s1_d;
         s1_vld_q   <= s1_vld_d;
         inflight_q <= inflight_d;
         sat_q      <= sat_d;
      end
   end

   assign pop = fifo_valid && i_dout_ready;

   sync_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_push   (push),
      .iv_din   (push_data),
      .i_pop    (pop),
      .ov_dout  (ov_dout),
      .o_valid  (fifo_valid),
      .ov_level (fifo_level)
   );

   assign o_ready      = ready_q;
   assign o_dout_valid = fifo_valid;
   assign o_sat        = sat_q;
   assign ov_level     = fifo_level;

endmodule

// File: tb/tb_fir_output_requant_fifo.sv
// Directed and randomized checks of the FIR requantizing output FIFO against an arithmetic model.
module tb_fir_output_requant_fifo;

   localparam int IN_W  = 24;
   localparam int OUT_W = 16;
   localparam int SH    = 8;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b1;
   logic [IN_W-1:0]  din = '0;
   logic             din_valid = 1'b0;
   logic             o_ready;
   logic [OUT_W-1:0] ov_dout;
   logic             o_dout_valid;
   logic             dout_ready = 1'b0;
   logic             o_sat;
   logic             sat_clr = 1'b0;
   logic [LW-1:0]    ov_level;

   int               tests = 0;
   int               fails = 0;
   logic [OUT_W-1:0] exp_q[$];
   bit               exp_sat = 1'b0;
   bit               rand_sink = 1'b0;
   bit               rand_en = 1'b0;
   logic [OUT_W-1:0] mon_exp;

   fir_output_requant_fifo #(
      .IN_WIDTH   (IN_W),
      .OUT_WIDTH  (OUT_W),
      .SHIFT      (SH),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .iv_din       (din),
      .i_din_valid  (din_valid),
      .o_ready      (o_ready),
      .ov_dout      (ov_dout),
      .o_dout_valid (o_dout_valid),
      .i_dout_ready (dout_ready),
      .o_sat        (o_sat),
      .i_sat_clr    (sat_clr),
      .ov_level     (ov_level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Rounding by floor division of (x + half LSB), then clamp to the output range.
   function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d, output bit sat);
      longint v, div, s, q, maxv, minv;
      v    = longint'($signed(d));
      div  = longint'(1) << SH;
      s    = v + div / 2;
      if (s >= 0) q = s / div;
      else        q = -((-s + div - 1) / div);
      maxv = (longint'(1) << (OUT_W - 1)) - 1;
      minv = -(longint'(1) << (OUT_W - 1));
      sat  = 1'b0;
      if (q > maxv) begin
         q = maxv; sat = 1'b1;
      end else if (q < minv) begin
         q = minv; sat = 1'b1;
      end
      return q[OUT_W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_sink) dout_ready = 1'($urandom_range(0, 1));
      if (rand_en)   en = ($urandom_range(0, 3) != 0);
   endtask

   task automatic expect_sample(input logic [IN_W-1:0] d);
      bit s;
      logic [OUT_W-1:0] e;
      e = model(d, s);
      exp_q.push_back(e);
      if (s) exp_sat = 1'b1;
   endtask

   // Filter-side driver: hold valid until o_ready is seen, then drop it one cycle later.
   task automatic send(input logic [IN_W-1:0] d);
      bit seen;
      seen      = 1'b0;
      din       = d;
      din_valid = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (o_ready) seen = 1'b1;
         else tick();
      end
      check("ready_seen", 64'(seen), 64'd1);
      if (seen) expect_sample(d);
      tick();
      din_valid = 1'b0;
      @(negedge clk);
      check("ready_one_cycle", 64'(o_ready), 64'd0);
      tick();
   endtask

   task automatic drain();
      dout_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      check("drain_model_empty", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("drain_dout_valid", 64'(o_dout_valid), 64'd0);
      check("drain_level", 64'(ov_level), 64'd0);
      tick();
   endtask

   always @(negedge clk) begin
      if (!rst && o_dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            check("dout_valid_unexpected", 64'(o_dout_valid), 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("dout", 64'(ov_dout), 64'(mon_exp));
         end
      end
   end

   initial begin
      int pulses;
      logic [OUT_W-1:0] head_ref;
      logic [IN_W-1:0] d;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_o_ready", 64'(o_ready), 64'd0);
      check("rst_dout", 64'(ov_dout), 64'd0);
      check("rst_dout_valid", 64'(o_dout_valid), 64'd0);
      check("rst_sat", 64'(o_sat), 64'd0);
      check("rst_level", 64'(ov_level), 64'd0);
      tick();
      rst = 1'b0;
      dout_ready = 1'b1;

      // 1: latency of +384 through an empty FIFO
      tick();
      din = 24'h000180;
      din_valid = 1'b1;
      @(negedge clk);
      check("t1_ready_n", 64'(o_ready), 64'd0);
      tick();
      @(negedge clk);
      check("t1_ready_n1", 64'(o_ready), 64'd1);
      expect_sample(24'h000180);
      tick();
      din_valid = 1'b0;
      @(negedge clk);
      check("t1_ready_n2", 64'(o_ready), 64'd0);
      check("t1_valid_n2", 64'(o_dout_valid), 64'd0);
      tick();
      @(negedge clk);
      check("t1_valid_n3", 64'(o_dout_valid), 64'd1);
      check("t1_dout_n3", 64'(ov_dout), 64'h0002);
      tick();

      // 2: -384 rounds half up to -1
      dout_ready = 1'b0;
      send(24'hFFFE80);
      @(negedge clk);
      check("t2_dout", 64'(ov_dout), 64'hFFFF);
      check("t2_sat", 64'(o_sat), 64'd0);
      dout_ready = 1'b1;
      tick();

      // 3: positive clamp, sticky flag, clear, then exact negative full scale
      dout_ready = 1'b0;
      send(24'h7FFFFF);
      @(negedge clk);
      check("t3_dout_max", 64'(ov_dout), 64'h7FFF);
      check("t3_sat_set", 64'(o_sat), 64'd1);
      dout_ready = 1'b1;
      tick();
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      exp_sat = 1'b0;
      @(negedge clk);
      check("t3_sat_clr", 64'(o_sat), 64'd0);
      tick();
      dout_ready = 1'b0;
      send(24'h800000);
      @(negedge clk);
      check("t3_dout_min", 64'(ov_dout), 64'h8000);
      check("t3_sat_min", 64'(o_sat), 64'd0);
      dout_ready = 1'b1;
      tick();
      tick();

      // 4: fill, stall the fifth sample, pop once, order preserved
      dout_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(24'(k * 24'h001300 + 24'h000081));
      repeat (2) tick();
      @(negedge clk);
      check("t4_level_full", 64'(ov_level), 64'd4);
      check("t4_valid_full", 64'(o_dout_valid), 64'd1);
      head_ref = exp_q[0];
      tick();
      din = 24'hFF0040;
      din_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t4_no_fifth_ready", 64'(o_ready), 64'd0);
         check("t4_head_stable", 64'(ov_dout), 64'(head_ref));
         tick();
      end
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      send(24'hFF0040);
      repeat (2) tick();
      @(negedge clk);
      check("t4_level_refill", 64'(ov_level), 64'd4);
      tick();
      drain();

      // 5: valid held through ACK and HOLD yields a single capture
      dout_ready = 1'b0;
      pulses = 0;
      din = 24'h012345;
      din_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (o_ready) pulses++;
         tick();
         if (i == 2) din_valid = 1'b0;
      end
      expect_sample(24'h012345);
      check("t5_pulses", 64'(pulses), 64'd1);
      @(negedge clk);
      check("t5_level", 64'(ov_level), 64'd1);
      tick();
      drain();

      // Randomized traffic with random sink back-pressure and enable
      rand_sink = 1'b1;
      rand_en = 1'b1;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0:       d = 24'($urandom);
            1:       d = 24'($signed(32'($urandom_range(0, 4095)) - 32'sd2048));
            2:       d = 24'h7FFFFF - 24'($urandom_range(0, 300));
            default: d = 24'h800000 + 24'($urandom_range(0, 300));
         endcase
         send(d);
         check("rand_sat", 64'(o_sat), 64'(exp_sat));
         if ($urandom_range(0, 7) == 0) begin
            sat_clr = 1'b1;
            tick();
            sat_clr = 1'b0;
            exp_sat = 1'b0;
         end
      end
      rand_sink = 1'b0;
      rand_en = 1'b0;
      en = 1'b1;
      drain();
      check("rand_sat_final", 64'(o_sat), 64'(exp_sat));

      // 6: reset during ACK with two entries queued
      dout_ready = 1'b0;
      send(24'h000400);
      send(24'h7FFF00);
      @(negedge clk);
      check("t6_level_pre", 64'(ov_level), 64'd2);
      din = 24'h001000;
      din_valid = 1'b1;
      tick();
      @(negedge clk);
      check("t6_in_ack", 64'(o_ready), 64'd1);
      rst = 1'b1;
      din_valid = 1'b0;
      tick();
      @(negedge clk);
      check("t6_rst_ready", 64'(o_ready), 64'd0);
      check("t6_rst_valid", 64'(o_dout_valid), 64'd0);
      check("t6_rst_level", 64'(ov_level), 64'd0);
      check("t6_rst_sat", 64'(o_sat), 64'd0);
      exp_q.delete();
      exp_sat = 1'b0;
      tick();
      rst = 1'b0;
      dout_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t6_no_stale_valid", 64'(o_dout_valid), 64'd0);
         check("t6_no_stale_ready", 64'(o_ready), 64'd0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
